seg7_scan_ctrl: RTL

//  Two-digit 7-segment scan controller feeding the 7-bit display mux stage (msb/lsb/dec).

---
 rtl/seg7_scan_ctrl_pkg.sv | 37 +++
 rtl/seg7_scan_ctrl_if.sv | 21 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types, constants and the hex-to-segment table
// for the two-digit 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] AN_LO     = 2'b01;
    localparam logic [1:0] AN_HI     = 2'b10;

    typedef enum logic {
        SLOT_LSB = 1'b0,
        SLOT_MSB = 1'b1
    } slot_e;

    // Segment order {g,f,e,d,c,b,a}, active-high, a = bit 0.
    function automatic logic [6:0] seg7_of(input logic [3:0] i_nib);
        seg7_of = SEG_BLANK;
        unique case (i_nib)
            4'h0: seg7_of = 7'h3F;
            4'h1: seg7_of = 7'h06;
            4'h2: seg7_of = 7'h5B;
            4'h3: seg7_of = 7'h4F;
            4'h4: seg7_of = 7'h66;
            4'h5: seg7_of = 7'h6D;
            4'h6: seg7_of = 7'h7D;
            4'h7: seg7_of = 7'h07;
            4'h8: seg7_of = 7'h7F;
            4'h9: seg7_of = 7'h6F;
            4'hA: seg7_of = 7'h77;
            4'hB: seg7_of = 7'h7C;
            4'hC: seg7_of = 7'h39;
            4'hD: seg7_of = 7'h5E;
            4'hE: seg7_of = 7'h79;
            4'hF: seg7_of = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Valid/ready byte channel feeding the scan controller.
// master = value source, slave = seg7_scan_ctrl.
interface seg7_scan_ctrl_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/hex_to_seg7.sv
// One-nibble hex to 7-segment decoder (active-high).
module hex_to_seg7
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = seg7_of(i_nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller: shadowed input,
// frame-aligned commit, digit decode and anode scan.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int DIV        = 50000,
    parameter int CW         = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus,
    input  logic             blank_lz,
    output logic [6:0]       msb,
    output logic [6:0]       lsb,
    output logic             dec,
    output logic [1:0]       an,
    output logic             frame_tick
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    slot_e         r_dec;
    logic          r_tick;
    logic [7:0]    r_shadow;
    logic          r_pend;
    logic [7:0]    r_disp;
    logic          r_live;

    logic          w_wrap;
    logic          w_frame;
    logic          w_acc;
    logic [6:0]    w_seg_hi;
    logic [6:0]    w_seg_lo;
    logic [6:0]    w_msb;
    logic [6:0]    w_lsb;
    logic [1:0]    w_an;

    assign w_wrap  = (r_cnt == CNT_LAST);
    assign w_frame = w_wrap & (r_dec == SLOT_MSB);
    assign w_acc   = bus.in_valid & ~r_pend;

    assign bus.in_ready = ~r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dec  <= SLOT_LSB;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_frame;
            if (w_wrap) begin
                r_cnt <= '0;
                r_dec <= (r_dec == SLOT_MSB) ? SLOT_LSB : SLOT_MSB;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // r_live keeps the display blank until the first commit after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_disp   <= '0;
            r_live   <= 1'b0;
        end else if (w_frame & r_pend) begin
            r_disp <= r_shadow;
            r_pend <= 1'b0;
            r_live <= 1'b1;
        end else if (w_acc) begin
            r_shadow <= bus.in_data;
            r_pend   <= 1'b1;
        end
    end

    hex_to_seg7 u_seg_hi (
        .i_nib (r_disp[7:4]),
        .o_seg (w_seg_hi)
    );

    hex_to_seg7 u_seg_lo (
        .i_nib (r_disp[3:0]),
        .o_seg (w_seg_lo)
    );

    always_comb begin
        w_lsb = r_live ? w_seg_lo : SEG_BLANK;
        w_msb = r_live ? w_seg_hi : SEG_BLANK;
        if (blank_lz && (r_disp[7:4] == 4'h0)) begin
            w_msb = SEG_BLANK;
        end
        w_an = (r_dec == SLOT_MSB) ? AN_HI : AN_LO;
    end

    assign msb        = ACTIVE_LOW ? ~w_msb : w_msb;
    assign lsb        = ACTIVE_LOW ? ~w_lsb : w_lsb;
    assign an         = ACTIVE_LOW ? ~w_an  : w_an;
    assign dec        = r_dec;
    assign frame_tick = r_tick;

endmodule
